encrypt_ctrl: RTL and testbench

- Sequencer that runs one full encryption pass over the shared 8x256 data memory.
- Reads the operands at [0], [1] and [2], then streams the 52-character message from [4:55].
- Pads it with a space preamble and trailer to 64 characters, XORs each character with a 5-bit LFSR keystream, and writes the result to [128:191].
- Sole master of the memory's read and write ports while busy. The testbench owns memory when idle.

---
 rtl/encrypt_ctrl_pkg.sv | 28 ++
 rtl/encrypt_ctrl_if.sv | 28 ++
 rtl/encrypt_ctrl_lfsr5.sv | 23 ++
 rtl/encrypt_ctrl.sv | 115 +++++++++++
 tb/tb_encrypt_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/encrypt_ctrl_pkg.sv
// Shared types and constants for the encryption sequencer.
package enc_pkg;

  // FSM encoding; the controller mirrors these as plain localparams.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LD_PRE  = 3'd1,
    ST_LD_TAP  = 3'd2,
    ST_LD_SEED = 3'd3,
    ST_RUN     = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [7:0] PAD_CHAR  = 8'h20;

  // Operand locations at the bottom of the shared memory.
  localparam logic [7:0] PRE_ADDR  = 8'd0;
  localparam logic [7:0] TAP_ADDR  = 8'd1;
  localparam logic [7:0] SEED_ADDR = 8'd2;

  // Default geometry of one pass.
  localparam int DEF_MSG_LEN  = 52;
  localparam int DEF_OUT_LEN  = 64;
  localparam int DEF_MSG_BASE = 4;
  localparam int DEF_OUT_BASE = 128;
  localparam int DEF_MAX_PRE  = 12;

endpackage

// File: rtl/encrypt_ctrl_if.sv
// Control and memory-port bundle between the sequencer and its environment.
//
// Handshake: start is a level sampled on posedge only while the sequencer is
// in IDLE or DONE; there is no ready back-pressure. busy marks the window in
// which the sequencer owns the memory ports. done is a level that holds until
// the next accepted start or reset. mem_rdata must be combinational from
// mem_raddr; a write lands on the posedge that closes a cycle with mem_we=1.
interface encrypt_ctrl_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [2:0] dbg_state;

  modport master (
    input  start, mem_rdata,
    output busy, done, mem_raddr, mem_waddr, mem_wdata, mem_we, dbg_state
  );

  modport slave (
    output start, mem_rdata,
    input  busy, done, mem_raddr, mem_waddr, mem_wdata, mem_we, dbg_state
  );
endinterface

// File: rtl/encrypt_ctrl_lfsr5.sv
// 5-bit Fibonacci-style LFSR with programmable taps, loadable seed.
module lfsr5 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] seed,
  input  logic [4:0] taps,
  input  logic       step,
  output logic [4:0] state
);

  // Load has priority over step; feedback is the parity of tapped bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= 5'd0;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= {state[3:0], ^(state & taps)};
    end
  end

endmodule

// File: rtl/encrypt_ctrl.sv
// Sequencer for one encryption pass: loads preamble length, taps and seed,
// then writes 64 padded, keystream-XORed characters to the output area.
module encrypt_ctrl
  import enc_pkg::*;
#(
  parameter int MSG_LEN  = DEF_MSG_LEN,
  parameter int OUT_LEN  = DEF_OUT_LEN,
  parameter int MSG_BASE = DEF_MSG_BASE,
  parameter int OUT_BASE = DEF_OUT_BASE,
  parameter int MAX_PRE  = DEF_MAX_PRE
) (
  input  logic          clk,
  input  logic          rst_n,
  encrypt_ctrl_if.master bus
);

  localparam logic [2:0] IDLE    = ST_IDLE;
  localparam logic [2:0] LD_PRE  = ST_LD_PRE;
  localparam logic [2:0] LD_TAP  = ST_LD_TAP;
  localparam logic [2:0] LD_SEED = ST_LD_SEED;
  localparam logic [2:0] RUN     = ST_RUN;
  localparam logic [2:0] DONE    = ST_DONE;

  localparam logic [6:0] LAST_IDX = 7'(OUT_LEN - 1);

  logic [2:0] state;
  logic [7:0] pre;
  logic [4:0] taps;
  logic [6:0] idx;
  logic [4:0] lfsr;

  logic [7:0] idx8;
  logic       is_pad;
  logic [7:0] msg_addr;
  logic [7:0] plain;

  lfsr5 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == LD_SEED),
    .seed  (bus.mem_rdata[4:0]),
    .taps  (taps),
    .step  (state == RUN),
    .state (lfsr)
  );

  // State transitions and operand capture at the closing edge of each cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pre   <= 8'd0;
      taps  <= 5'd0;
      idx   <= 7'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) state <= LD_PRE;
        end
        LD_PRE: begin
          pre   <= (bus.mem_rdata > 8'(MAX_PRE)) ? 8'(MAX_PRE) : bus.mem_rdata;
          state <= LD_TAP;
        end
        LD_TAP: begin
          taps  <= bus.mem_rdata[4:0];
          state <= LD_SEED;
        end
        LD_SEED: begin
          idx   <= 7'd0;
          state <= RUN;
        end
        RUN: begin
          idx <= idx + 7'd1;
          if (idx == LAST_IDX) state <= DONE;
        end
        DONE: begin
          if (bus.start) state <= LD_PRE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Padding window and message read address for the current output index.
  always_comb begin
    idx8     = {1'b0, idx};
    is_pad   = (idx8 < pre) || (idx8 >= (pre + 8'(MSG_LEN)));
    msg_addr = 8'(MSG_BASE) + idx8 - pre;
    plain    = is_pad ? PAD_CHAR : bus.mem_rdata;
  end

  // Memory port drive and status outputs, all decoded from current state.
  always_comb begin
    bus.mem_raddr = 8'd0;
    bus.mem_waddr = 8'd0;
    bus.mem_wdata = 8'd0;
    bus.mem_we    = 1'b0;
    case (state)
      LD_PRE:  bus.mem_raddr = PRE_ADDR;
      LD_TAP:  bus.mem_raddr = TAP_ADDR;
      LD_SEED: bus.mem_raddr = SEED_ADDR;
      RUN: begin
        bus.mem_raddr = is_pad ? 8'd0 : msg_addr;
        bus.mem_we    = 1'b1;
        bus.mem_waddr = 8'(OUT_BASE) + idx8;
        bus.mem_wdata = plain ^ {3'b000, lfsr};
      end
      default: ;
    endcase
    bus.busy      = (state == LD_PRE) || (state == LD_TAP) ||
                    (state == LD_SEED) || (state == RUN);
    bus.done      = (state == DONE);
    bus.dbg_state = state;
  end

endmodule

// File: tb/tb_encrypt_ctrl.sv
// Directed bench for encrypt_ctrl: table of passes plus reset-abort sequence.
module tb_encrypt_ctrl;
  import enc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  encrypt_ctrl_if bus();

  encrypt_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- memory model ----------------
  logic [7:0] mem [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_addr = 8'd0;
  logic [7:0] tb_data = 8'd0;
  int         wr_cnt = 0;

  assign bus.mem_rdata = mem[bus.mem_raddr];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_waddr] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end
  end

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];
  logic [7:0] ref_msg [52];

  typedef struct {
    logic [7:0] p_raw;
    logic [4:0] taps;
    logic [4:0] seed;
    logic       ramp;
    logic [7:0] fill;
    logic       mid_start;
    logic [7:0] ca [3];
    logic [7:0] cv [3];
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic mem_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1;
    tb_addr = a;
    tb_data = d;
    @(posedge clk);
    #1;
    tb_we = 1'b0;
  endtask

  task automatic load(input logic [7:0] p_raw, input logic [4:0] tp, input logic [4:0] sd,
                      input logic ramp, input logic [7:0] fill);
    logic [7:0] b;
    mem_wr(PRE_ADDR, p_raw);
    mem_wr(TAP_ADDR, {3'b000, tp});
    mem_wr(SEED_ADDR, {3'b000, sd});
    for (int k = 0; k < 52; k++) begin
      b = ramp ? (8'h61 + 8'(k % 26)) : fill;
      ref_msg[k] = b;
      mem_wr(8'(4 + k), b);
    end
  endtask

  task automatic fill_out(input logic [7:0] v);
    for (int a = 128; a < 192; a++) mem_wr(8'(a), v);
  endtask

  function automatic logic [7:0] model_byte(input int i, input logic [7:0] p_raw,
                                            input logic [4:0] tp, input logic [4:0] sd);
    int p;
    logic [4:0] l;
    logic [7:0] pl;
    p = (p_raw > 8'd12) ? 12 : int'(p_raw);
    l = sd;
    for (int k = 0; k < i; k++) l = {l[3:0], ^(l & tp)};
    pl = (i < p || i >= p + 52) ? 8'h20 : ref_msg[i - p];
    return pl ^ {3'b000, l};
  endfunction

  // Issues start, optionally re-pulses start mid-RUN, and measures done latency.
  task automatic run_pass(input logic mid_start, input string tag);
    int base;
    int lat;
    @(negedge clk);
    base = wr_cnt;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({tag, "_busy_on_start"}, 32'(bus.busy), 32'd1);
    check({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      bus.start = (mid_start && n == 13) ? 1'b1 : 1'b0;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    bus.start = 1'b0;
    check({tag, "_done_latency"}, 32'(lat), 32'd67);
    check({tag, "_write_count"}, 32'(wr_cnt - base), 32'd64);
    @(posedge clk);
    #1;
    check({tag, "_done_hold"}, {30'd0, bus.done, bus.mem_we}, 32'd2);
  endtask

  // ---------------- test body ----------------
  initial begin
    string tag;
    logic [7:0] e;
    bus.start = 1'b0;

    // P=12, taps 0x12, seed 1, all 'A': keystream 01,02,05,... lfsr_12 = 0x18.
    vecs[0] = '{8'd12, 5'h12, 5'h01, 1'b0, 8'h41, 1'b0,
                '{8'd128, 8'd130, 8'd140}, '{8'h21, 8'h25, 8'h59}};
    // seed 0, P=7, ramp 'a'..: ciphertext equals padded plaintext; mid-RUN start.
    vecs[1] = '{8'd7, 5'h05, 5'h00, 1'b1, 8'h00, 1'b1,
                '{8'd134, 8'd135, 8'd186}, '{8'h20, 8'h61, 8'h7A}};
    // P=20 clamps to 12: first message byte at 140, last at 191.
    vecs[2] = '{8'd20, 5'h1D, 5'h00, 1'b1, 8'h00, 1'b0,
                '{8'd139, 8'd140, 8'd191}, '{8'h20, 8'h61, 8'h7A}};
    // P=0, taps 0, seed 1F: keystream 1F,1E,1C,18,10,00...; 12 trailing pads.
    vecs[3] = '{8'd0, 5'h00, 5'h1F, 1'b0, 8'h41, 1'b0,
                '{8'd128, 8'd133, 8'd191}, '{8'h5E, 8'h41, 8'h20}};
    // P=255 clamps to 12, taps 1F, seed 0B: keystream 0B,17,0E.
    vecs[4] = '{8'd255, 5'h1F, 5'h0B, 1'b1, 8'h00, 1'b0,
                '{8'd128, 8'd129, 8'd130}, '{8'h2B, 8'h37, 8'h2E}};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("rst_flags", {29'd0, bus.busy, bus.done, bus.mem_we}, 32'd0);
    check("rst_addrs", {8'd0, bus.mem_raddr, bus.mem_waddr, bus.mem_wdata}, 32'd0);
    rst_n = 1'b1;

    // Back-to-back passes; all but the first restart from DONE.
    for (int v = 0; v < 5; v++) begin
      tag = $sformatf("v%0d", v);
      load(vecs[v].p_raw, vecs[v].taps, vecs[v].seed, vecs[v].ramp, vecs[v].fill);
      for (int i = 0; i < 64; i++)
        exp_q.push_back(model_byte(i, vecs[v].p_raw, vecs[v].taps, vecs[v].seed));
      run_pass(vecs[v].mid_start, tag);
      for (int c = 0; c < 3; c++)
        check($sformatf("%s_hand%0d", tag, c), 32'(mem[vecs[v].ca[c]]), 32'(vecs[v].cv[c]));
      for (int a = 128; a < 192; a++) begin
        e = exp_q.pop_front();
        check($sformatf("%s_byte%0d", tag, a), 32'(mem[a]), 32'(e));
      end
    end

    // Reset mid-RUN at i=30: abort, leave unwritten output untouched.
    load(8'd3, 5'h09, 5'h15, 1'b1, 8'h00);
    fill_out(8'hEE);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (33) begin
      @(posedge clk);
      #1;
    end
    check("abort_in_run", 32'(bus.dbg_state), 32'(ST_RUN));
    check("abort_idx30", 32'(bus.mem_waddr), 32'd158);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("abort_flags", {29'd0, bus.busy, bus.done, bus.mem_we}, 32'd0);
    rst_n = 1'b1;
    check("abort_last_write", 32'(mem[158]), 32'(model_byte(30, 8'd3, 5'h09, 5'h15)));
    for (int a = 159; a < 192; a++)
      check($sformatf("abort_keep%0d", a), 32'(mem[a]), 32'hEE);

    // Fresh pass from IDLE after the abort.
    for (int i = 0; i < 64; i++)
      exp_q.push_back(model_byte(i, 8'd3, 5'h09, 5'h15));
    run_pass(1'b0, "post_abort");
    for (int a = 128; a < 192; a++) begin
      e = exp_q.pop_front();
      check($sformatf("post_abort_byte%0d", a), 32'(mem[a]), 32'(e));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
